// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
//
// Execute-stage requester for the RV32M multiply/divide unit. An M-extension
// op held by the execute stage is accepted when the muldiv unit is idle, its
// operands are latched, a single-cycle enable is issued, and the controller
// waits for busy to drop before capturing the result and presenting it for
// writeback. The pipeline is stalled for the whole operation except in the
// writeback cycle.
//
// Parameters:
//   XLEN          operand/result width (only 32 supported)
//   BUSY_TIMEOUT  max WAIT cycles before the watchdog fires (0 = disabled)
//
// Build option:
//   M_DIV_FASTPATH_EN  when defined, divide-by-zero and signed-overflow divides
//                      are resolved locally without starting the muldiv unit.
//
// Ports:
//   i_clk_n      clock, all state updates on its rising edge
//   i_rst        synchronous active-high reset
//   i_valid      execute stage holds an M op (fields stable while stalled)
//   i_flush      pipeline flush, aborts the current op
//   i_funct3     M op select (000 MUL .. 111 REMU)
//   i_rs1/i_rs2  operands A and B
//   i_rd         destination register
//   o_md_en      one-cycle start pulse to muldiv
//   o_md_funct3  latched op select to muldiv
//   o_md_a/o_md_b latched operands to muldiv
//   i_md_result  muldiv result
//   i_md_busy    muldiv busy
//   o_stall      hold the pipeline
//   o_wb_valid   one-cycle writeback strobe
//   o_wb_rd      writeback register
//   o_wb_data    writeback data
//   o_timeout    sticky watchdog flag
// ---------------------------------------------------------------------------
module md_issue_ctrl #(
  parameter int XLEN         = 32,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  output logic            o_md_en,
  output logic [2:0]      o_md_funct3,
  output logic [XLEN-1:0] o_md_a,
  output logic [XLEN-1:0] o_md_b,
  input  logic [XLEN-1:0] i_md_result,
  input  logic            i_md_busy,
  output logic            o_stall,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The counter only has to reach BUSY_TIMEOUT-1, the last WAIT cycle index.
  localparam int               CNT_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (BUSY_TIMEOUT > 0) ? CNT_W'(BUSY_TIMEOUT - 1) : '0;
  localparam bit               WDOG_EN  = (BUSY_TIMEOUT != 0);

  localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       r_state;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_wb_data;
  logic             r_timeout;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_fast;

  logic             w_accept;
  logic             w_fast_hit;
  logic [XLEN-1:0]  w_fast_data;

  // An op is only taken when muldiv is idle, so a leftover operation started
  // before a flush or reset is allowed to drain first.
  assign w_accept = (r_state == S_IDLE) & i_valid & ~i_flush & ~i_md_busy;

`ifdef M_DIV_FASTPATH_EN
  // Detection uses the live inputs at accept; the result is formed from the
  // latched operands in the following slot, which doubles as the pipeline
  // register between detection and writeback.
  always_comb begin
    w_fast_hit  = i_funct3[2] &
                  ((i_rs2 == '0) | ((i_rs1 == SIGN_MIN) & (i_rs2 == '1) & ~i_funct3[0]));
    w_fast_data = '0;
    if (r_b == '0)
      w_fast_data = r_funct3[1] ? r_a : '1;
    else
      w_fast_data = r_funct3[1] ? '0 : SIGN_MIN;
  end
`else
  assign w_fast_hit  = 1'b0;
  assign w_fast_data = '0;
`endif

  // Main controller. Flush has priority in every state; latched operands are
  // deliberately left untouched by a flush so the muldiv inputs never glitch
  // under an operation that may still be running.
  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_funct3   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rd       <= '0;
      r_wb_data  <= '0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
      r_fast     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3 <= i_funct3;
            r_a      <= i_rs1;
            r_b      <= i_rs2;
            r_rd     <= i_rd;
            r_fast   <= w_fast_hit;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          if (i_flush) begin
            r_state <= S_IDLE;
          end else if (r_fast) begin
            r_wb_data <= w_fast_data;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else if (!i_md_busy) begin
            r_wb_data <= i_md_result;
            r_state   <= S_DONE;
          end else if (WDOG_EN && (r_wait_cnt == CNT_LAST)) begin
            r_timeout <= 1'b1;
            r_wb_data <= '0;
            r_state   <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The enable is a pure decode of ISSUE, so it can never last longer than
  // one cycle; fast-path ops skip it because muldiv is not needed.
  assign o_md_en     = (r_state == S_ISSUE) & ~r_fast;
  assign o_md_funct3 = r_funct3;
  assign o_md_a      = r_a;
  assign o_md_b      = r_b;

  // Stall is released only in DONE so the pipeline advances together with
  // the writeback strobe.
  assign o_stall    = i_valid & (r_state != S_DONE);
  assign o_wb_valid = (r_state == S_DONE) & ~i_flush;
  assign o_wb_rd    = r_rd;
  assign o_wb_data  = r_wb_data;
  assign o_timeout  = r_timeout;

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Execute-stage requester for the RV32M multiply/divide unit. Accepts a decoded M-extension op from the pipeline and latches its operands. Issues a single-cycle enable to the muldiv unit and holds its inputs stable until the result is captured. Stalls the pipeline meanwhile, then presents the result for writeback.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
BUSY_TIMEOUT, 64, max cycles in WAIT before watchdog fires (0 = watchdog disabled)

Ports:
i_clk_n  in  1  clock; all state updates on posedge
i_rst  in  1  reset, synchronous, active-high
i_valid  in  1  execute stage holds an M op; held with stable fields while o_stall=1
i_flush  in  1  pipeline flush; aborts current op
i_funct3  in  3  M op select (000 MUL .. 111 REMU)
i_rs1  in  32  operand A
i_rs2  in  32  operand B
i_rd  in  5  destination register
o_md_en  out  1  enable pulse to muldiv
o_md_funct3  out  3  latched funct3 to muldiv
o_md_a  out  32  latched operand A to muldiv
o_md_b  out  32  latched operand B to muldiv
i_md_result  in  32  muldiv result
i_md_busy  in  1  muldiv busy
o_stall  out  1  hold pipeline
o_wb_valid  out  1  writeback strobe, one cycle
o_wb_rd  out  5  writeback register
o_wb_data  out  32  writeback data
o_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: state=IDLE. o_md_en=0, o_wb_valid=0, o_timeout=0, o_md_a/o_md_b/o_md_funct3/o_wb_rd/o_wb_data=0. Reset mid-operation returns to IDLE immediately. Muldiv state is not touched, so a later accept waits for i_md_busy low.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If i_valid & !i_flush & !i_md_busy: latch funct3/rs1/rs2/rd, then go to ISSUE.
  - If i_valid & i_md_busy (a leftover op after a flush): stay in IDLE.
- ISSUE: o_md_en=1 for exactly this cycle, then go to WAIT. o_md_en is never high in any other state.
- WAIT:
  - Entered the cycle after the enable edge.
  - If !i_md_busy: register i_md_result into o_wb_data and go to DONE.
  - Busy low in the first WAIT cycle is legal (fast multiplier, or slow multiply with rs2=0).
- DONE: o_wb_valid=1, o_wb_rd=latched rd, then go to IDLE. The pipeline advances this cycle.
- o_stall = i_valid & (state != DONE). It is combinational and also covers the IDLE cycle.
- Latency from accept cycle to o_wb_valid: 3 + (busy cycles).
  - Fast multiply: 3.
  - Divide: 35 (32 busy cycles).
- Input stability: muldiv sign/select post-processing is combinational on its inputs. o_md_a, o_md_b and o_md_funct3 come only from latched registers and are unchanged from ISSUE through WAIT capture.
- Flush:
  - In ISSUE or WAIT: go to IDLE, no writeback, latched regs kept.
  - In DONE: writeback suppressed (o_wb_valid forced 0).
  - Flush has priority over all other transitions.
- Watchdog: a WAIT cycle counter reloads on entry. If BUSY_TIMEOUT≠0 and the counter reaches BUSY_TIMEOUT: set o_timeout (sticky until reset) and go to DONE with o_wb_data=0.
- Simultaneous i_flush and i_valid in IDLE: do not accept.

Optional Feature:
M_DIV_FASTPATH_EN
- Defined: in IDLE, on accept of a div op (funct3[2]=1), detect the following cases and go directly to DONE without pulsing o_md_en:
  - rs2=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (funct3=100/110, rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - Fast-path latency is 2 cycles from accept to o_wb_valid.
- Undefined: all div ops go through muldiv; results are whatever muldiv produces.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> one o_md_en pulse. o_wb_data=0xFFFFFFEB, o_wb_rd latched. o_md_a/o_md_b stable until capture; o_stall low only in DONE.
- DIVU 100/7 -> o_wb_data=14, o_wb_valid exactly 35 cycles after accept. REM 0xFFFFFFF9 by 2 -> 0xFFFFFFFF.
- DIV 100/3, flush 5 cycles after accept -> no o_wb_valid. Next MUL 3*4 (i_valid held) is not accepted until i_md_busy falls, then writes back 12.
- Reset asserted mid-divide -> next cycle all outputs at reset values, state IDLE. A following MULHU 0xFFFFFFFF*2 returns 1.
- With M_DIV_FASTPATH_EN:
  - DIVU 5/0 -> 0xFFFFFFFF in 2 cycles, o_md_en never high.
  - DIV 0x80000000/-1 -> 0x80000000.
  - Without the macro, o_md_en pulses once.
- BUSY_TIMEOUT=4 with i_md_busy forced high -> o_timeout=1 after 4 WAIT cycles, o_wb_valid=1 with o_wb_data=0; o_timeout stays high.
